node_sequencer: RTL and testbench
=================================

NODE_SEQUENCER -- requirements
Module: node_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- THRESH, 30: sensor dark threshold; a sensor bit is set when sensor > THRESH.
- SETTLE, 16: stop-settle cycles before measuring.
- TIMEOUT, 1024: maximum cycles to wait for colour_done.
- MAX_NODES, 8: node count after which the bot parks.
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1: single clock.
- reset_n, in, 1: asynchronous, active-low reset.
- sensorL, in, 10: left reflectance sample.
- sensorC, in, 10: centre reflectance sample.
- sensorR, in, 10: right reflectance sample.
- colour_done, in, 1: colour measurement complete (pulse).
- colour_code, in, 2: colour result, valid with colour_done.
- tx_ready, in, 1: XBee UART can accept a byte.
- AF, AB, BF, BB, out, 1 each: motor controls, active low.
- colour_start, out, 1: one-cycle measurement request.
- tx_valid, out, 1: byte offered to the UART.
- tx_data, out, 8: byte to transmit.
- node_count, out, 4: nodes serviced so far.
- busy, out, 1: high in any state except FOLLOW.

Function
REQ-003 Sensor pattern p[2:0] = {L,C,R} SHALL be registered every cycle, with bit = (sensor > THRESH); sensor == THRESH reads 0.
REQ-004 Motor outputs SHALL be registered, giving 2-cycle latency from sensor input to motor output.
REQ-005 Motor encodings {AF,AB,BF,BB}:
- straight = 0101
- right = 1101
- left = 0111
- stop = 1111
REQ-006 In FOLLOW, p maps to motor drive as follows:
- 010 -> straight
- 100 -> right
- 001 -> left
- 101 -> straight
- 000 -> stop
REQ-007 Node pattern: p in {110, 011, 111}. Node is detected when the node pattern is present on 2 consecutive registered cycles; a single-cycle occurrence SHALL be ignored and the bot drives straight.
REQ-008 State machine states: FOLLOW, SETTLE, MEASURE, REPORT, CLEAR, PARK.
REQ-009 FOLLOW -> SETTLE on node detect; motors = stop from that cycle onward.
REQ-010 SETTLE SHALL hold stop for SETTLE cycles, then enter MEASURE with colour_start high for exactly one cycle.
REQ-011 MEASURE SHALL wait for colour_done and latch colour_code.
- If TIMEOUT cycles elapse without colour_done, set the timeout flag t=1 and colour = 00.
- colour_done arriving on the same cycle as timeout SHALL count as done (t=0).
- Motors remain stopped.
REQ-012 REPORT SHALL send 2 bytes in order:
- byte0 = {4'hA, node_count}, using the pre-increment count.
- byte1 = {t, 5'b0, colour}.
REQ-013 Handshake: a byte transfers on a cycle with tx_valid & tx_ready.
- tx_data SHALL be stable and tx_valid SHALL not drop until transfer.
- Back-to-back transfer on consecutive cycles is allowed.
- tx_valid SHALL be low outside REPORT.
REQ-014 After byte1 transfers, node_count SHALL increment by 1, saturating at 15.
- If the new count == MAX_NODES, go to PARK; otherwise go to CLEAR.
REQ-015 CLEAR SHALL drive straight, ignoring node patterns, until p is a non-node pattern for 4 consecutive cycles, then return to FOLLOW.
REQ-016 PARK: motors stop, busy = 1; the block stays in PARK until reset.
REQ-017 colour_done outside MEASURE SHALL be ignored.
REQ-018 tx_ready is ignored when tx_valid is low.

Reset
REQ-019 Asserting reset_n low at any time, including mid-REPORT, SHALL immediately force the following; no partial byte is reissued after reset:
- state FOLLOW
- motors = 1111
- colour_start = 0, tx_valid = 0, tx_data = 0
- node_count = 0, busy = 0
- timers and pattern register cleared
REQ-020 After reset release, the first motor drive SHALL reflect sensors sampled on or after the first clock edge.

Verification
REQ-021 Line following: L=C=R=10 then C=500 -> motors 0101 two cycles after C changes; then L=500, C=10 -> 1101.
REQ-022 Node debounce: L=C=500, R=10 for 1 cycle only -> state stays FOLLOW. Held for 2 cycles -> busy=1, motors 1111, colour_start pulses 16 cycles later.
REQ-023 Full node service: colour_done with code 2'b10, tx_ready held high.
- Expected bytes: 0xA0 then 0x02 on consecutive cycles; node_count = 1.
- Then CLEAR drives 0101; FOLLOW resumes after 4 non-node cycles.
REQ-024 Timeout and backpressure: no colour_done for 1024 cycles -> byte1 = 0x80. With tx_ready low for 5 cycles, tx_valid and tx_data stay stable.
REQ-025 Park and reset: service 8 nodes -> PARK, motors 1111, node_count = 8. Then assert reset_n low mid-REPORT of a fresh run -> tx_valid = 0 and node_count = 0 immediately.
REQ-026 Threshold boundary: all sensors = 30 -> p = 000 -> motors 1111. Sensors = 31 -> p = 111 -> node detected.

Source files
------------

// File: rtl/node_sequencer.sv
// node_sequencer: line-following node controller.
//   Registers a 3-bit dark/light pattern from the left/centre/right
//   reflectance sensors and steers the motors from it. A node (two adjacent
//   dark sensors or all three dark) seen on two consecutive samples stops the
//   bot, waits for it to settle, requests a colour measurement, reports
//   {node id, colour} as two UART bytes, and then drives straight off the
//   node. After MAX_NODES nodes the bot parks until reset.
// Ports:
//   clock, reset_n              - clock, asynchronous active-low reset
//   sensorL/C/R [9:0]           - reflectance samples (dark when > THRESH)
//   colour_done, colour_code    - measurement complete pulse and result
//   tx_ready                    - UART can accept a byte
//   AF, AB, BF, BB              - registered motor controls, active low
//   colour_start                - one-cycle measurement request
//   tx_valid, tx_data [7:0]     - byte offered to the UART
//   node_count [3:0]            - nodes serviced, saturating at 15
//   busy                        - high whenever not line-following
module node_sequencer #(
  parameter int THRESH    = 30,
  parameter int SETTLE    = 16,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_NODES = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [9:0] sensorL,
  input  logic [9:0] sensorC,
  input  logic [9:0] sensorR,
  input  logic       colour_done,
  input  logic [1:0] colour_code,
  input  logic       tx_ready,
  output logic       AF,
  output logic       AB,
  output logic       BF,
  output logic       BB,
  output logic       colour_start,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic [3:0] node_count,
  output logic       busy
);

  localparam logic [9:0] THR = 10'(THRESH);
  localparam int CW = $clog2((TIMEOUT > SETTLE) ? TIMEOUT : SETTLE) + 2;

  localparam logic [3:0] M_STRAIGHT = 4'b0101;
  localparam logic [3:0] M_RIGHT    = 4'b1101;
  localparam logic [3:0] M_LEFT     = 4'b0111;
  localparam logic [3:0] M_STOP     = 4'b1111;

  typedef enum logic [2:0] {
    S_FOLLOW,
    S_SETTLE,
    S_MEASURE,
    S_REPORT,
    S_CLEAR,
    S_PARK
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    p_q, p_d;
  logic          node_prev_q, node_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    motor_q, motor_d;
  logic          cstart_q, cstart_d;
  logic [1:0]    colour_q, colour_d;
  logic          tout_q, tout_d;
  logic          sel_q, sel_d;
  logic [3:0]    count_q, count_d;

  logic          p_is_node;
  logic          detect;
  logic [3:0]    count_inc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FOLLOW;
      p_q         <= '0;
      node_prev_q <= 1'b0;
      cnt_q       <= '0;
      motor_q     <= '1;
      cstart_q    <= 1'b0;
      colour_q    <= '0;
      tout_q      <= 1'b0;
      sel_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      node_prev_q <= node_prev_d;
      cnt_q       <= cnt_d;
      motor_q     <= motor_d;
      cstart_q    <= cstart_d;
      colour_q    <= colour_d;
      tout_q      <= tout_d;
      sel_q       <= sel_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    p_d         = {sensorL > THR, sensorC > THR, sensorR > THR};
    p_is_node   = (p_q == 3'b110) || (p_q == 3'b011) || (p_q == 3'b111);
    // node_prev_q remembers whether the previous registered pattern was a node
    node_prev_d = p_is_node;
    detect      = p_is_node && node_prev_q;
    count_inc   = (count_q == 4'hF) ? 4'hF : count_q + 4'd1;

    state_d  = state_q;
    cnt_d    = cnt_q;
    cstart_d = 1'b0;
    colour_d = colour_q;
    tout_d   = tout_q;
    sel_d    = sel_q;
    count_d  = count_q;

    case (state_q)
      S_FOLLOW: begin
        if (detect) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          state_d  = S_MEASURE;
          cnt_d    = '0;
          cstart_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MEASURE: begin
        // done is tested first so a result on the final cycle is not a timeout
        if (colour_done) begin
          state_d  = S_REPORT;
          colour_d = colour_code;
          tout_d   = 1'b0;
          sel_d    = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d  = S_REPORT;
          colour_d = '0;
          tout_d   = 1'b1;
          sel_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REPORT: begin
        if (tx_ready) begin
          if (!sel_q) begin
            sel_d = 1'b1;
          end else begin
            count_d = count_inc;
            cnt_d   = '0;
            state_d = (count_inc == 4'(MAX_NODES)) ? S_PARK : S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        // count consecutive non-node samples; any node sample restarts it
        if (p_is_node) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(3)) begin
          state_d = S_FOLLOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARK: begin
        state_d = S_PARK;
      end
      default: begin
        state_d = S_FOLLOW;
      end
    endcase

    // motors follow the state being entered so the stop lands on detection
    case (state_d)
      S_FOLLOW: begin
        case (p_q)
          3'b100:  motor_d = M_RIGHT;
          3'b001:  motor_d = M_LEFT;
          3'b000:  motor_d = M_STOP;
          default: motor_d = M_STRAIGHT;
        endcase
      end
      S_CLEAR: motor_d = M_STRAIGHT;
      default: motor_d = M_STOP;
    endcase
  end

  assign {AF, AB, BF, BB} = motor_q;
  assign colour_start     = cstart_q;
  assign node_count       = count_q;
  assign busy             = (state_q != S_FOLLOW);
  assign tx_valid         = (state_q == S_REPORT);
  assign tx_data          = (state_q != S_REPORT) ? 8'h00 :
                            sel_q ? {tout_q, 5'b0, colour_q} : {4'hA, count_q};

endmodule

// File: tb/tb_node_sequencer.sv
// Self-checking bench for node_sequencer: directed stimulus in the main
// process, a scoreboard queue of expected UART bytes, and a monitor that pops
// and compares on every tx handshake and checks data stability under stall.
module tb_node_sequencer;

  localparam int TIMEOUT   = 1024;
  localparam int MAX_NODES = 8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [9:0] sensorL, sensorC, sensorR;
  logic       colour_done;
  logic [1:0] colour_code;
  logic       tx_ready;
  logic       AF, AB, BF, BB;
  logic       colour_start;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [3:0] node_count;
  logic       busy;
  logic [3:0] mot;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [3:0] mcount;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;

  assign mot = {AF, AB, BF, BB};

  node_sequencer #(
    .THRESH(30),
    .SETTLE(16),
    .TIMEOUT(TIMEOUT),
    .MAX_NODES(MAX_NODES)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .sensorL(sensorL),
    .sensorC(sensorC),
    .sensorR(sensorR),
    .colour_done(colour_done),
    .colour_code(colour_code),
    .tx_ready(tx_ready),
    .AF(AF),
    .AB(AB),
    .BF(BF),
    .BB(BB),
    .colour_start(colour_start),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .node_count(node_count),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_s(input int l, input int c, input int r);
    sensorL = 10'(l);
    sensorC = 10'(c);
    sensorR = 10'(r);
  endtask

  // Monitor: every handshake consumes one expected byte; a stalled byte must
  // still be offered, unchanged, on the next cycle.
  always @(negedge clock) begin
    if (reset_n) begin
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL tx_byte: got %0h expected %0h", tx_data, e);
          end
        end
      end
      if (hold_pend) begin
        checks++;
        if (!tx_valid || tx_data !== hold_data) begin
          errors++;
          $display("FAIL tx_stable: got valid=%0b data=%0h expected valid=1 data=%0h",
                   tx_valid, tx_data, hold_data);
        end
      end
      hold_pend = tx_valid && !tx_ready;
      hold_data = tx_data;
    end else begin
      hold_pend = 1'b0;
    end
  end

  // One full node: detect on all-31 sensors, settle, measure (done after dly
  // cycles, or never when dly < 0), report with tx_ready held high.
  task automatic svc(input logic [1:0] code, input int dly);
    logic [7:0] b1;
    int n;
    tx_ready = 1'b1;
    set_s(31, 31, 31);
    step(2);
    chk("pre_detect_busy", busy, 0);
    step(1);
    chk("detect_busy", busy, 1);
    chk("detect_motor", mot, 4'b1111);
    set_s(10, 500, 10);
    step(15);
    chk("settle_cstart_low", colour_start, 0);
    step(1);
    chk("cstart_pulse", colour_start, 1);
    b1 = (dly >= 0 && dly < TIMEOUT) ? {6'b0, code} : 8'h80;
    exp_q.push_back({4'hA, mcount});
    exp_q.push_back(b1);
    if (dly >= 0) begin
      step(dly);
      colour_done = 1'b1;
      colour_code = code;
      step(1);
      colour_done = 1'b0;
      colour_code = 2'b00;
    end
    n = 0;
    while (!tx_valid && n < 1100) begin
      step(1);
      n++;
    end
    chk("report_reached", tx_valid, 1);
    n = 0;
    while (tx_valid && n < 10) begin
      step(1);
      n++;
    end
    chk("report_back_to_back", n, 2);
    mcount = mcount + 4'd1;
    chk("node_count", node_count, mcount);
    if (int'(mcount) == MAX_NODES) begin
      chk("park_busy", busy, 1);
      chk("park_motor", mot, 4'b1111);
    end else begin
      chk("clear_motor", mot, 4'b0101);
      step(3);
      chk("clear_busy", busy, 1);
      step(1);
      chk("follow_resume", busy, 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n     = 1'b0;
    colour_done = 1'b0;
    colour_code = 2'b00;
    tx_ready    = 1'b0;
    mcount      = 4'd0;
    set_s(10, 10, 10);
    step(2);
    chk("rst_motor", mot, 4'b1111);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_count", node_count, 0);
    chk("rst_cstart", colour_start, 0);
    reset_n = 1'b1;

    // line following and the 2-cycle latency
    step(2);
    chk("follow_000", mot, 4'b1111);
    set_s(10, 500, 10);
    step(1);
    chk("latency_hold", mot, 4'b1111);
    step(1);
    chk("follow_010", mot, 4'b0101);
    set_s(500, 10, 10);
    step(2);
    chk("follow_100", mot, 4'b1101);
    set_s(10, 10, 500);
    step(2);
    chk("follow_001", mot, 4'b0111);
    set_s(500, 10, 500);
    step(2);
    chk("follow_101", mot, 4'b0101);
    set_s(30, 30, 30);
    step(2);
    chk("thresh_eq_motor", mot, 4'b1111);
    chk("thresh_eq_busy", busy, 0);
    set_s(10, 500, 10);
    step(2);

    // single-sample node pattern is ignored
    set_s(500, 500, 10);
    step(1);
    set_s(10, 500, 10);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("glitch_busy", busy, 0);
      chk("glitch_motor", mot, 4'b0101);
    end

    // node 1: code 10, bytes A0 then 02
    svc(2'b10, 0);

    // node 2: stray colour_done in SETTLE, timeout, backpressure
    tx_ready = 1'b0;
    set_s(10, 500, 500);
    step(3);
    chk("n2_busy", busy, 1);
    set_s(10, 500, 10);
    colour_done = 1'b1;
    colour_code = 2'b11;
    step(1);
    colour_done = 1'b0;
    colour_code = 2'b00;
    step(14);
    chk("n2_cstart_low", colour_start, 0);
    step(1);
    chk("n2_cstart", colour_start, 1);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'h80);
    n = 0;
    while (!tx_valid && n < 1100) begin
      step(1);
      n++;
    end
    chk("timeout_cycles", n, TIMEOUT);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", tx_valid, 1);
      chk("stall_byte0", tx_data, 8'hA1);
      step(1);
    end
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    chk("byte1_timeout", tx_data, 8'h80);
    step(2);
    chk("stall_byte1", tx_data, 8'h80);
    chk("stall_valid1", tx_valid, 1);
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    chk("n2_done_valid", tx_valid, 0);
    chk("n2_count", node_count, 2);
    chk("n2_clear_motor", mot, 4'b0101);
    mcount = 4'd2;
    // a node pattern during CLEAR is driven over and restarts the count
    set_s(31, 31, 31);
    step(1);
    set_s(10, 500, 10);
    step(1);
    chk("clear_node_motor", mot, 4'b0101);
    chk("clear_node_busy", busy, 1);
    step(3);
    chk("clear_restart_busy", busy, 1);
    step(1);
    chk("clear_exit", busy, 0);

    // node 3: done on the final timeout cycle counts as done
    svc(2'b01, TIMEOUT - 1);

    // nodes 4..8, the last one parks
    for (int i = 4; i <= MAX_NODES; i++) svc(2'(i), i % 3);
    set_s(31, 31, 31);
    step(5);
    chk("park_hold_busy", busy, 1);
    chk("park_hold_motor", mot, 4'b1111);
    chk("park_hold_valid", tx_valid, 0);
    chk("park_hold_count", node_count, 8);

    // reset out of PARK, then reset again mid-REPORT
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    exp_q.delete();
    mcount = 4'd0;
    set_s(10, 500, 10);
    step(2);
    chk("post_reset_follow", mot, 4'b0101);
    chk("post_reset_count", node_count, 0);
    svc(2'b11, 0);
    tx_ready = 1'b0;
    set_s(31, 31, 31);
    step(3);
    set_s(10, 500, 10);
    step(16);
    chk("mid_cstart", colour_start, 1);
    colour_done = 1'b1;
    colour_code = 2'b01;
    step(1);
    colour_done = 1'b0;
    colour_code = 2'b00;
    chk("mid_report_valid", tx_valid, 1);
    chk("mid_report_byte0", tx_data, 8'hA1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid", tx_valid, 0);
    chk("async_data", tx_data, 0);
    chk("async_count", node_count, 0);
    chk("async_busy", busy, 0);
    chk("async_motor", mot, 4'b1111);
    chk("async_cstart", colour_start, 0);
    tx_ready = 1'b1;
    step(2);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("no_reissue", tx_valid, 0);
    end
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
